branch_resolve_unit: RTL and testbench

Write side of the branch target buffer: tracks every fetched instruction's predicted next-PC in an in-order queue and compares it with the next-PC the execute stage resolves. On a mismatch it redirects fetch, flushes the queue, and issues one BTB write of the actual `{PC, NPC}` pair. It sits between the execute stage and the BTB write port, alongside the fetch stage's BTB read port.

---
 rtl/bpu_pkg.sv | 32 +++
 rtl/branch_resolve_unit_pred_fifo.sv | 97 +++++++++
 rtl/branch_resolve_unit.sv | 171 +++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bpu_pkg.sv
// ---------------------------------------------------------------------------
// bpu_pkg
// Shared types and constants for the branch resolve unit and its prediction
// queue.
//   ADDR_W        : PC width
//   PC_INC        : sequential (fall-through) PC increment
//   pred_entry_t  : one in-flight prediction {pc, npc_pred}
//   bru_state_t   : resolve FSM states
// ---------------------------------------------------------------------------
package bpu_pkg;

    localparam int ADDR_W  = 16;
    localparam int ENTRY_W = 2 * ADDR_W;

    localparam logic [ADDR_W-1:0] PC_INC = 16'd4;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] npc_pred;
    } pred_entry_t;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_REDIRECT = 1'b1
    } bru_state_t;

    // Fall-through successor of a PC (wraps modulo 2^ADDR_W).
    function automatic logic [ADDR_W-1:0] seq_next_pc(input logic [ADDR_W-1:0] pc);
        return pc + PC_INC;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_pred_fifo.sv
// ---------------------------------------------------------------------------
// pred_fifo
// In-order queue of fetched predictions. Clear has priority over push/pop.
// Push while full and pop while empty are ignored. Full/empty come from an
// occupancy counter one bit wider than the pointers.
// Ports:
//   clk, rst       : clock, async active-high reset
//   push_i         : append push_data_i at the tail
//   push_data_i    : packed pred_entry_t
//   pop_i          : drop the head entry
//   clear_i        : empty the queue
//   head_o         : current head entry (undefined while empty)
//   full_o,empty_o : occupancy flags
// ---------------------------------------------------------------------------
module pred_fifo
    import bpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_i,
    input  logic [ENTRY_W-1:0] push_data_i,
    input  logic               pop_i,
    input  logic               clear_i,
    output logic [ENTRY_W-1:0] head_o,
    output logic               full_o,
    output logic               empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]   count_q,  count_d;
    logic               do_push_s;
    logic               do_pop_s;

    assign full_o    = (count_q == OCC_W'(DEPTH));
    assign empty_o   = (count_q == OCC_W'(0));
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;
    assign head_o    = mem_q[rd_ptr_q];

    // Next pointer/occupancy values; pointers wrap naturally (DEPTH is 2^n).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = PTR_W'(0);
            rd_ptr_d = PTR_W'(0);
            count_d  = OCC_W'(0);
        end else begin
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (do_push_s && !do_pop_s) begin
                count_d = count_q + OCC_W'(1);
            end else if (do_pop_s && !do_push_s) begin
                count_d = count_q - OCC_W'(1);
            end else begin
                count_d = count_q;
            end
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            count_q  <= OCC_W'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (do_push_s && !clear_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
// Tracks each fetched instruction's predicted next-PC and checks it against
// the next-PC resolved by execute. A mismatch flushes the queue, pulses a
// fetch redirect and issues one BTB write of the actual {pc, npc} pair.
// Ports:
//   fetch_valid/fetch_pc/fetch_npc_pred/fetch_ready : prediction push side
//   resolve_valid/resolve_pc/resolve_npc             : in-order retire side
//   redirect/redirect_pc                             : fetch redirect pulse
//   btb_we/btb_pc_actual/btb_npc_actual              : BTB write port
//   resolve_count/mispredict_count                   : saturating statistics
//   sync_err                                         : sticky queue desync flag
// ---------------------------------------------------------------------------
module branch_resolve_unit
    import bpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_valid,
    input  logic [ADDR_W-1:0] fetch_pc,
    input  logic [ADDR_W-1:0] fetch_npc_pred,
    output logic              fetch_ready,
    input  logic              resolve_valid,
    input  logic [ADDR_W-1:0] resolve_pc,
    input  logic [ADDR_W-1:0] resolve_npc,
    output logic              redirect,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              btb_we,
    output logic [ADDR_W-1:0] btb_pc_actual,
    output logic [ADDR_W-1:0] btb_npc_actual,
    output logic [CNT_W-1:0]  resolve_count,
    output logic [CNT_W-1:0]  mispredict_count,
    output logic              sync_err
);

    bru_state_t         state_q, state_d;
    logic [ENTRY_W-1:0] head_raw_s;
    pred_entry_t        head_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic               resolve_fire_s;
    logic               pop_s;
    logic               pc_mismatch_s;
    logic               npc_mismatch_s;
    logic               mispredict_s;
    logic               push_s;

    logic              redirect_q,    redirect_d;
    logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;
    logic              btb_we_q,      btb_we_d;
    logic [ADDR_W-1:0] btb_pc_q,      btb_pc_d;
    logic [ADDR_W-1:0] btb_npc_q,     btb_npc_d;
    logic [CNT_W-1:0]  res_cnt_q,     res_cnt_d;
    logic [CNT_W-1:0]  mis_cnt_q,     mis_cnt_d;
    logic              sync_err_q,    sync_err_d;

    assign head_s      = head_raw_s;
    // Full queue blocks pushes even when a pop is in flight: no pass-through.
    assign fetch_ready = (state_q == ST_RUN) && !fifo_full_s;

    pred_fifo #(
        .DEPTH (DEPTH)
    ) u_pred_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_s),
        .push_data_i ({fetch_pc, fetch_npc_pred}),
        .pop_i       (pop_s),
        .clear_i     (mispredict_s),
        .head_o      (head_raw_s),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s)
    );

    // Head compare. A PC mismatch is a desync and is handled as a mispredict
    // so fetch restarts from a known-good target. Flush beats same-cycle push.
    always_comb begin
        resolve_fire_s = resolve_valid && (state_q == ST_RUN);
        pop_s          = resolve_fire_s && !fifo_empty_s;
        pc_mismatch_s  = (head_s.pc != resolve_pc);
        npc_mismatch_s = (head_s.npc_pred != resolve_npc);
        mispredict_s   = pop_s && (pc_mismatch_s || npc_mismatch_s);
        push_s         = fetch_valid && fetch_ready && !mispredict_s;
    end

    // FSM next state: REDIRECT always lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (mispredict_s) begin
                    state_d = ST_REDIRECT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_REDIRECT: state_d = ST_RUN;
            default:     state_d = ST_RUN;
        endcase
    end

    // Next values of the registered outputs and saturating counters.
    always_comb begin
        redirect_d    = mispredict_s;
        btb_we_d      = mispredict_s;
        redirect_pc_d = redirect_pc_q;
        btb_pc_d      = btb_pc_q;
        btb_npc_d     = btb_npc_q;
        res_cnt_d     = res_cnt_q;
        mis_cnt_d     = mis_cnt_q;
        if (mispredict_s) begin
            redirect_pc_d = resolve_npc;
            btb_pc_d      = resolve_pc;
            btb_npc_d     = resolve_npc;
        end else begin
            redirect_pc_d = redirect_pc_q;
            btb_pc_d      = btb_pc_q;
            btb_npc_d     = btb_npc_q;
        end
        if (pop_s && !(&res_cnt_q)) begin
            res_cnt_d = res_cnt_q + CNT_W'(1);
        end else begin
            res_cnt_d = res_cnt_q;
        end
        if (mispredict_s && !(&mis_cnt_q)) begin
            mis_cnt_d = mis_cnt_q + CNT_W'(1);
        end else begin
            mis_cnt_d = mis_cnt_q;
        end
        sync_err_d = sync_err_q ||
                     (resolve_fire_s && (fifo_empty_s || pc_mismatch_s));
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_RUN;
            redirect_q    <= 1'b0;
            redirect_pc_q <= 16'h0000;
            btb_we_q      <= 1'b0;
            btb_pc_q      <= 16'h0000;
            btb_npc_q     <= 16'h0000;
            res_cnt_q     <= CNT_W'(0);
            mis_cnt_q     <= CNT_W'(0);
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            btb_we_q      <= btb_we_d;
            btb_pc_q      <= btb_pc_d;
            btb_npc_q     <= btb_npc_d;
            res_cnt_q     <= res_cnt_d;
            mis_cnt_q     <= mis_cnt_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign redirect         = redirect_q;
    assign redirect_pc      = redirect_pc_q;
    assign btb_we           = btb_we_q;
    assign btb_pc_actual    = btb_pc_q;
    assign btb_npc_actual   = btb_npc_q;
    assign resolve_count    = res_cnt_q;
    assign mispredict_count = mis_cnt_q;
    assign sync_err         = sync_err_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

    localparam int DEPTH   = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst;
    logic              fetch_valid;
    logic [15:0]       fetch_pc;
    logic [15:0]       fetch_npc_pred;
    logic              fetch_ready;
    logic              resolve_valid;
    logic [15:0]       resolve_pc;
    logic [15:0]       resolve_npc;
    logic              redirect;
    logic [15:0]       redirect_pc;
    logic              btb_we;
    logic [15:0]       btb_pc_actual;
    logic [15:0]       btb_npc_actual;
    logic [CNT_W-1:0]  resolve_count;
    logic [CNT_W-1:0]  mispredict_count;
    logic              sync_err;

    branch_resolve_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .fetch_valid      (fetch_valid),
        .fetch_pc         (fetch_pc),
        .fetch_npc_pred   (fetch_npc_pred),
        .fetch_ready      (fetch_ready),
        .resolve_valid    (resolve_valid),
        .resolve_pc       (resolve_pc),
        .resolve_npc      (resolve_npc),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .btb_we           (btb_we),
        .btb_pc_actual    (btb_pc_actual),
        .btb_npc_actual   (btb_npc_actual),
        .resolve_count    (resolve_count),
        .mispredict_count (mispredict_count),
        .sync_err         (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: in-flight predictions as a plain queue of {pc, npc}.
    logic [31:0] mq[$];
    bit          m_in_redirect;
    logic [15:0] m_rpc, m_bpc, m_bnpc;
    int          m_rcnt, m_mcnt;
    bit          m_serr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_in_redirect = 1'b0;
        m_rpc = 16'h0; m_bpc = 16'h0; m_bnpc = 16'h0;
        m_rcnt = 0; m_mcnt = 0; m_serr = 1'b0;
    endtask

    // One clock: check fetch_ready, advance the model, clock, check outputs.
    task automatic cycle(input string tag);
        logic [31:0] h;
        bit ready, acc, mis;
        ready = !m_in_redirect && (mq.size() < DEPTH);
        chk({tag, ".fetch_ready"}, {31'd0, fetch_ready}, {31'd0, ready});
        acc = fetch_valid && ready;
        mis = 1'b0;
        if (!m_in_redirect && resolve_valid) begin
            if (mq.size() == 0) begin
                m_serr = 1'b1;
            end else begin
                h = mq.pop_front();
                if (m_rcnt < CNT_MAX) m_rcnt++;
                if (h[31:16] != resolve_pc) m_serr = 1'b1;
                if (h != {resolve_pc, resolve_npc}) mis = 1'b1;
            end
        end
        if (mis) begin
            mq.delete();
            acc    = 1'b0;
            m_rpc  = resolve_npc;
            m_bpc  = resolve_pc;
            m_bnpc = resolve_npc;
            if (m_mcnt < CNT_MAX) m_mcnt++;
        end
        if (acc) mq.push_back({fetch_pc, fetch_npc_pred});
        m_in_redirect = mis;
        @(posedge clk); #1;
        chk({tag, ".redirect"}, {31'd0, redirect}, {31'd0, mis});
        chk({tag, ".btb_we"}, {31'd0, btb_we}, {31'd0, mis});
        if (mis) begin
            chk({tag, ".redirect_pc"}, {16'd0, redirect_pc}, {16'd0, m_rpc});
            chk({tag, ".btb_pc"}, {16'd0, btb_pc_actual}, {16'd0, m_bpc});
            chk({tag, ".btb_npc"}, {16'd0, btb_npc_actual}, {16'd0, m_bnpc});
        end
        chk({tag, ".resolve_count"}, 32'(resolve_count), 32'(m_rcnt));
        chk({tag, ".mispredict_count"}, 32'(mispredict_count), 32'(m_mcnt));
        chk({tag, ".sync_err"}, {31'd0, sync_err}, {31'd0, m_serr});
    endtask

    task automatic step(input string tag, input bit fv, input logic [15:0] fpc,
                        input logic [15:0] fnpc, input bit rv,
                        input logic [15:0] rpc, input logic [15:0] rnpc);
        fetch_valid = fv; fetch_pc = fpc; fetch_npc_pred = fnpc;
        resolve_valid = rv; resolve_pc = rpc; resolve_npc = rnpc;
        cycle(tag);
        fetch_valid = 1'b0;
        resolve_valid = 1'b0;
    endtask

    task automatic push(input string tag, input logic [15:0] pc, input logic [15:0] npc);
        step(tag, 1'b1, pc, npc, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic resolve(input string tag, input logic [15:0] pc, input logic [15:0] npc);
        step(tag, 1'b0, 16'h0, 16'h0, 1'b1, pc, npc);
    endtask

    // Asynchronous reset: outputs must read reset values before any clock edge.
    task automatic do_reset(input string tag);
        fetch_valid = 1'b0;
        resolve_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk({tag, ".redirect"}, {31'd0, redirect}, 32'd0);
        chk({tag, ".btb_we"}, {31'd0, btb_we}, 32'd0);
        chk({tag, ".redirect_pc"}, {16'd0, redirect_pc}, 32'd0);
        chk({tag, ".btb_pc"}, {16'd0, btb_pc_actual}, 32'd0);
        chk({tag, ".btb_npc"}, {16'd0, btb_npc_actual}, 32'd0);
        chk({tag, ".resolve_count"}, 32'(resolve_count), 32'd0);
        chk({tag, ".mispredict_count"}, 32'(mispredict_count), 32'd0);
        chk({tag, ".sync_err"}, {31'd0, sync_err}, 32'd0);
        chk({tag, ".fetch_ready"}, {31'd0, fetch_ready}, 32'd1);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] h;
        logic [15:0] fpc, fnpc, rpc, rnpc;
        bit fv, rv;

        rst = 1'b0;
        fetch_valid = 1'b0; fetch_pc = 16'h0; fetch_npc_pred = 16'h0;
        resolve_valid = 1'b0; resolve_pc = 16'h0; resolve_npc = 16'h0;
        model_reset();
        #2;
        do_reset("por");

        // All predictions correct.
        push("ok.p0", 16'h0000, 16'h0004);
        push("ok.p1", 16'h0004, 16'h0008);
        push("ok.p2", 16'h0008, 16'h000C);
        resolve("ok.r0", 16'h0000, 16'h0004);
        resolve("ok.r1", 16'h0004, 16'h0008);
        resolve("ok.r2", 16'h0008, 16'h000C);
        chk("ok.count3", 32'(resolve_count), 32'd3);
        chk("ok.nomis", 32'(mispredict_count), 32'd0);
        resolve("ok.empty", 16'h000C, 16'h0010);
        chk("ok.empty_serr", {31'd0, sync_err}, 32'd1);

        // Taken-branch mispredict.
        do_reset("rst_taken");
        push("tk.p0", 16'h0010, 16'h0014);
        resolve("tk.r0", 16'h0010, 16'h0040);
        chk("tk.redirect", {31'd0, redirect}, 32'd1);
        chk("tk.redirect_pc", {16'd0, redirect_pc}, 32'h0040);
        chk("tk.btb_pc", {16'd0, btb_pc_actual}, 32'h0010);
        chk("tk.btb_npc", {16'd0, btb_npc_actual}, 32'h0040);
        chk("tk.mis1", 32'(mispredict_count), 32'd1);
        chk("tk.ready_lo", {31'd0, fetch_ready}, 32'd0);
        step("tk.redir", 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0);
        chk("tk.ready_hi", {31'd0, fetch_ready}, 32'd1);
        chk("tk.sync_ok", {31'd0, sync_err}, 32'd0);

        // Flush discards younger entries and the same-cycle push.
        do_reset("rst_flush");
        push("fl.p0", 16'h0010, 16'h0014);
        push("fl.p1", 16'h0014, 16'h0018);
        push("fl.p2", 16'h0018, 16'h001C);
        step("fl.mis", 1'b1, 16'h001C, 16'h0020, 1'b1, 16'h0010, 16'h0040);
        step("fl.redir_ign", 1'b1, 16'h0050, 16'h0054, 1'b1, 16'h0014, 16'h0018);
        resolve("fl.r_empty", 16'h0014, 16'h0018);
        chk("fl.sync_err", {31'd0, sync_err}, 32'd1);
        chk("fl.cnt", 32'(resolve_count), 32'd1);

        // Full queue, no pass-through, then wrap-around ordering.
        do_reset("rst_full");
        for (int i = 0; i < DEPTH; i++)
            push("fu.fill", 16'h0100 + 16'(4 * i), 16'h0104 + 16'(4 * i));
        chk("fu.ready_lo", {31'd0, fetch_ready}, 32'd0);
        step("fu.pop_push", 1'b1, 16'h0110, 16'h0114, 1'b1, 16'h0100, 16'h0104);
        chk("fu.ready_hi", {31'd0, fetch_ready}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            h = mq[0];
            step("fu.wrap", 1'b1, 16'h0200 + 16'(4 * i), 16'h0204 + 16'(4 * i),
                 1'b1, h[31:16], h[15:0]);
        end
        while (mq.size() > 0) begin
            h = mq[0];
            resolve("fu.drain", h[31:16], h[15:0]);
        end
        chk("fu.nomis", 32'(mispredict_count), 32'd0);
        chk("fu.nosync", {31'd0, sync_err}, 32'd0);

        // Fall-through mispredict.
        do_reset("rst_ft");
        push("ft.p0", 16'h0100, 16'h0200);
        resolve("ft.r0", 16'h0100, 16'h0104);
        chk("ft.btb_we", {31'd0, btb_we}, 32'd1);
        chk("ft.btb_pc", {16'd0, btb_pc_actual}, 32'h0100);
        chk("ft.btb_npc", {16'd0, btb_npc_actual}, 32'h0104);
        chk("ft.redirect_pc", {16'd0, redirect_pc}, 32'h0104);

        // Reset asserted while redirect is high.
        do_reset("rst_pre_mid");
        push("rm.p0", 16'h0300, 16'h0304);
        push("rm.p1", 16'h0304, 16'h0308);
        resolve("rm.r0", 16'h0300, 16'h0380);
        chk("rm.redirect_hi", {31'd0, redirect}, 32'd1);
        do_reset("rst_mid");
        resolve("rm.empty", 16'h0304, 16'h0308);
        chk("rm.empty_serr", {31'd0, sync_err}, 32'd1);

        // Randomized traffic against the model (counters saturate at CNT_W=4).
        do_reset("rst_rand");
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 149) == 0) do_reset("rand_rst");
            fv   = ($urandom_range(0, 3) != 0);
            fpc  = 16'($urandom()) & 16'hFFFC;
            fnpc = ($urandom_range(0, 3) == 0) ? (16'($urandom()) & 16'hFFFC) : fpc + 16'd4;
            rv   = ($urandom_range(0, 1) == 1);
            if (mq.size() > 0 && $urandom_range(0, 7) != 0) begin
                h    = mq[0];
                rpc  = h[31:16];
                rnpc = ($urandom_range(0, 5) == 0) ? (16'($urandom()) & 16'hFFFC) : h[15:0];
            end else begin
                rpc  = 16'($urandom()) & 16'hFFFC;
                rnpc = 16'($urandom()) & 16'hFFFC;
            end
            step("rand", fv, fpc, fnpc, rv, rpc, rnpc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
